// File: rtl/button_input_conditioner_if.sv
// button_input_conditioner_if: button pins in, debounced levels, pulses and divided clock out.
interface button_input_conditioner_if #(
   parameter int NUM_BUTTONS = 3
);
   logic [NUM_BUTTONS-1:0] i_button;
   logic [NUM_BUTTONS-1:0] o_state;
   logic [NUM_BUTTONS-1:0] o_button;
   logic                   o_clock;
   modport master (output i_button, input o_state, o_button, o_clock);
   modport slave  (input i_button, output o_state, o_button, o_clock);
endinterface

// File: rtl/button_input_conditioner.sv
// button_input_conditioner: synchronize, debounce and pulse raw buttons; free-running clock divider.
// Auto-repeat of held buttons is built only when BUTTON_REPEAT_EN is defined.
module button_input_conditioner #(
   parameter int NUM_BUTTONS     = 3,
   parameter int SCALE           = 12,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_PERIOD   = 1200000
) (
   input logic                  i_clock,
   input logic                  i_reset,
   button_input_conditioner_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
      $error("button_input_conditioner: cycle limits must be >= 2");
   end
   logic [NUM_BUTTONS-1:0] s1, sync, state, pulse;
   logic [SCALE-1:0]       div, div_nx;
   logic                   clk_q;
   assign div_nx       = div + 1'b1;
   assign bus.o_state  = state;
   assign bus.o_button = pulse;
   assign bus.o_clock  = clk_q;
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         s1    <= '0;
         sync  <= '0;
         div   <= '0;
         clk_q <= 1'b0;
      end else begin
         s1    <= bus.i_button;
         sync  <= s1;
         div   <= div_nx;
         clk_q <= div_nx[SCALE-1];
      end
   end
`ifdef BUTTON_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX);
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rp_state_t;
`endif
   for (genvar c = 0; c < NUM_BUTTONS; c++) begin : g_ch
      logic          st, st_q, pls, rise, fall;
      logic [DW-1:0] db_cnt;
      assign state[c] = st;
      assign pulse[c] = pls;
      assign rise     = st & ~st_q;
      assign fall     = ~st & st_q;
      always_ff @(posedge i_clock) begin
         if (i_reset) begin
            db_cnt <= '0;
            st     <= 1'b0;
            st_q   <= 1'b0;
         end else begin
            st_q <= st;
            if (sync[c] == st) db_cnt <= '0;
            else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               st     <= sync[c];
               db_cnt <= '0;
            end else db_cnt <= db_cnt + 1'b1;
         end
      end
`ifdef BUTTON_REPEAT_EN
      rp_state_t     rs, rs_n;
      logic [RW-1:0] rp_cnt, rp_cnt_n;
      logic          pls_n;
      always_ff @(posedge i_clock) begin
         if (i_reset) begin
            rs     <= IDLE;
            rp_cnt <= '0;
            pls    <= 1'b0;
         end else begin
            rs     <= rs_n;
            rp_cnt <= rp_cnt_n;
            pls    <= pls_n;
         end
      end
      // a release overrides any pulse due in the same cycle
      always_comb begin
         rs_n     = rs;
         rp_cnt_n = rp_cnt + 1'b1;
         pls_n    = 1'b0;
         if (fall) begin
            rs_n     = IDLE;
            rp_cnt_n = '0;
         end else begin
            case (rs)
               IDLE: begin
                  rp_cnt_n = '0;
                  pls_n    = rise;
                  rs_n     = rise ? DELAY : IDLE;
               end
               DELAY: if (rp_cnt == RW'(REPEAT_DELAY - 1)) begin
                  pls_n    = 1'b1;
                  rp_cnt_n = '0;
                  rs_n     = REPEAT;
               end
               REPEAT: if (rp_cnt == RW'(REPEAT_PERIOD - 1)) begin
                  pls_n    = 1'b1;
                  rp_cnt_n = '0;
               end
               default: begin
                  rs_n     = IDLE;
                  rp_cnt_n = '0;
               end
            endcase
         end
      end
`else
      always_ff @(posedge i_clock) begin
         if (i_reset) pls <= 1'b0;
         else pls <= rise;
      end
`endif
   end
endmodule

// File: tb/tb_button_input_conditioner.sv
// tb_button_input_conditioner: scoreboard bench; expected edges/pulses queued at stimulus time.
module tb_button_input_conditioner;
   localparam int N = 3, S = 3, D = 4, RD = 20, RP = 8;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] btn = '1;
   logic [N-1:0] prev_st = '0;
   int cyc = 0, since = 0, total = 0, bad = 0;
   int rel_at [N];
   typedef struct {int cyc; int ch; int val;} ev_t;
   ev_t pq[$], sq[$];
   button_input_conditioner_if #(.NUM_BUTTONS(N)) bif ();
   assign bif.i_button = btn;
   button_input_conditioner #(
      .NUM_BUTTONS(N), .SCALE(S), .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (.i_clock(clk), .i_reset(rst), .bus(bif.slave));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      since <= rst ? 0 : since + 1;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic int find(input ev_t q[$], input int ch);
      foreach (q[i]) if (q[i].ch == ch) return i;
      return -1;
   endfunction
   task automatic monitor();
      int i;
      check("o_clock", bif.o_clock, (since / (2 ** (S - 1))) % 2);
      for (int ch = 0; ch < N; ch++) begin
         if (bif.o_state[ch] !== prev_st[ch]) begin
            i = find(sq, ch);
            if (i < 0) check($sformatf("xstate%0d", ch), cyc, -1);
            else begin
               check($sformatf("state%0d_cyc", ch), cyc, sq[i].cyc);
               check($sformatf("state%0d_val", ch), bif.o_state[ch], sq[i].val);
               sq.delete(i);
            end
            prev_st[ch] = bif.o_state[ch];
         end
         if (bif.o_button[ch] === 1'b1) begin
            i = find(pq, ch);
            if (i < 0) check($sformatf("xpulse%0d", ch), cyc, -1);
            else begin
               check($sformatf("pulse%0d_cyc", ch), cyc, pq[i].cyc);
               pq.delete(i);
            end
         end
      end
   endtask
   task automatic tick();
      @(negedge clk);
      monitor();
      for (int ch = 0; ch < N; ch++) if (rel_at[ch] == cyc) btn[ch] = 1'b0;
   endtask
   task automatic wait_n(input int n);
      repeat (n) tick();
   endtask
   // input driven at negedge m lands before edge m+1, so o_state moves at edge m+D+2
   task automatic expect_press(input int ch, input int m, input int len);
      if (len >= D) begin
         sq.push_back('{m + D + 2, ch, 1});
         pq.push_back('{m + D + 3, ch, 0});
`ifdef BUTTON_REPEAT_EN
         for (int t = m + D + 3 + RD; t <= m + len + D + 2; t += RP) pq.push_back('{t, ch, 0});
`endif
         sq.push_back('{m + len + D + 2, ch, 0});
      end
   endtask
   task automatic press(input int ch, input int len);
      btn[ch] = 1'b1;
      rel_at[ch] = cyc + len;
      expect_press(ch, cyc, len);
   endtask
   initial begin
      for (int ch = 0; ch < N; ch++) rel_at[ch] = -1;
      repeat (3) begin
         tick();
         check("rst_state", bif.o_state, 0);
         check("rst_button", bif.o_button, 0);
         check("rst_clock", bif.o_clock, 0);
      end
      rst = 1'b0;
      for (int ch = 0; ch < N; ch++) begin
         rel_at[ch] = cyc + 12;
         expect_press(ch, cyc, 12);
      end
      wait_n(30);
      press(0, 3);
      wait_n(20);
      press(1, 35);
      wait_n(60);
      press(1, 100);
      wait_n(120);
      press(0, 40);
      wait_n(3);
      press(2, 40);
      wait_n(80);
      check("pulses_left", pq.size(), 0);
      check("states_left", sq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/button_input_conditioner.md
# button_input_conditioner

Input-conditioning front end for the LED-panel design: debounces raw mechanical push-buttons, turns held buttons into auto-repeating single-cycle pulses, and provides a free-running divided clock. It sits between the board button pins and the panel/cursor logic. It combines the debouncer, repeater and clock-divider functions in one synchronous block.

## Interface
- `NUM_BUTTONS`, 3: number of independent button channels.
- `SCALE`, 12: divider counter width; `o_clock` period is 2^SCALE input cycles.
- `DEBOUNCE_CYCLES`, 120000: consecutive stable cycles required before the debounced level changes. Must be ≥2.
- `REPEAT_DELAY`, 6000000: cycles from the first press pulse to the first repeat pulse. Must be ≥2.
- `REPEAT_PERIOD`, 1200000: cycles between subsequent repeat pulses. Must be ≥2.
- `i_clock` input 1: single system clock; all logic is on its rising edge.
- `i_reset` input 1: reset, synchronous and active-high.
- `i_button` input NUM_BUTTONS: raw active-high buttons, asynchronous to `i_clock`.
- `o_state` output NUM_BUTTONS: debounced button level, one bit per channel.
- `o_button` output NUM_BUTTONS: one-cycle press/repeat pulses, one bit per channel.
- `o_clock` output 1: divided clock, 50% duty.

## Operation
- Each channel is independent. Counter widths are $clog2 of their limits.
- **Synchronizer**
  - Two-flop synchronizer on each `i_button` bit, producing `sync`.
- **Debounce**
  - Per-channel counter `db_cnt`.
  - If `sync == o_state`, `db_cnt` is 0.
  - Otherwise `db_cnt` increments each cycle.
  - When `db_cnt == DEBOUNCE_CYCLES-1` and `sync != o_state`, `o_state` takes the value of `sync` and `db_cnt` is 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `o_state`.
- **Repeater**
  - States: IDLE, DELAY, REPEAT.
  - IDLE: on an `o_state` rising edge (registered previous value), pulse `o_button` for one cycle, load `rp_cnt`=0 and go to DELAY.
  - DELAY: increment `rp_cnt`. At `REPEAT_DELAY-1`, pulse `o_button`, clear `rp_cnt` and go to REPEAT.
  - REPEAT: increment `rp_cnt`. At `REPEAT_PERIOD-1`, pulse and clear.
  - `o_state` falling in any state: go to IDLE, clear `rp_cnt`, and force `o_button` low the same cycle.
  - A rising and falling edge cannot coincide, because `o_state` changes at most once per DEBOUNCE_CYCLES.
- **Divider**
  - Free-running SCALE-bit counter, incrementing every cycle and wrapping from 2^SCALE-1 to 0.
  - `o_clock` = counter[SCALE-1], registered.
- **Reset** (any time, including mid-debounce or mid-repeat):
  - Synchronizers, `o_state`, `db_cnt`, `rp_cnt` and the divider counter are 0.
  - Repeater goes to IDLE.
  - `o_state`=0, `o_button`=0, `o_clock`=0.
  - A button held through reset release is treated as a new press once debounced.

## Timing
- The raw input changes before edge k. `sync` reflects it after edge k+1.
- `o_state` updates at edge k+1+DEBOUNCE_CYCLES, provided the input stays stable.
- `o_button` first pulse is high for exactly the one cycle after the `o_state` rise.
- The first repeat pulse rises REPEAT_DELAY cycles after the first pulse.
- Later repeat pulses rise every REPEAT_PERIOD cycles.
- `o_button` is low in the cycle after `o_state` falls; no pulse is emitted after release.
- `o_clock`:
  - Low for 2^(SCALE-1) cycles after reset, then toggles every 2^(SCALE-1) cycles.
  - Phase depends only on reset, not on button activity.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro `BUTTON_REPEAT_EN`.
  - Defined: repeater behaves as above (DELAY/REPEAT auto-repeat).
  - Undefined: exactly one `o_button` pulse per debounced press. DELAY/REPEAT and `rp_cnt` are compiled out. `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
All scenarios use `SCALE`=3, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- **Reset**: hold `i_reset` 3 cycles with buttons high -> `o_state`=0, `o_button`=0, `o_clock`=0 during reset. `o_clock` rises 4 cycles after release and has period 8.
- **Glitch rejection**: button 0 high for 3 cycles, then low -> `o_state[0]` stays 0 and `o_button[0]` never pulses.
- **Clean press**: button 1 rises before edge k and holds -> `o_state[1]`=1 at edge k+5. One-cycle `o_button[1]` pulse the next cycle. Repeats at +20, +28 and +36 cycles.
- **Release**: drop button 1 at a repeat-pulse boundary -> `o_state[1]` falls 5 edges later. No further pulses. `o_button[1]` is low the cycle after the fall.
- **Independence**: press buttons 0 and 2 three cycles apart -> each channel shows the same latency, offset by 3 cycles. No cross-talk.
- **Build without `BUTTON_REPEAT_EN`**: 100-cycle hold -> exactly one `o_button` pulse.
